// File: rtl/time_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : time_pkg
//  Description : Shared state encodings and sizing helpers for time setting.
//  Revision    : 1.0 - initial release
// ============================================================================
package time_pkg;

  localparam int c_mode_w = 3;

  typedef enum logic [c_mode_w-1:0] {
    RUN      = 3'd0,
    SET_SEC  = 3'd1,
    SET_MIN  = 3'd2,
    SET_HOUR = 3'd3,
    SET_DAY  = 3'd4
  } mode_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : 2-flop synchronizer, stable-count debouncer, press pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int DEB_CYCLES = 270000,
  parameter int CNT_W      = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] c_deb_last = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  // press rises together with the debounced level, so it is a one-cycle edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 != r_level) begin
        if (r_cnt == c_deb_last) begin
          r_level <= r_sync2;
          r_press <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : time_set_ctrl
//  Description : Mode/up button front end for setting a clock's time fields.
//  Revision    : 1.0 - initial release
// ============================================================================
module time_set_ctrl
  import time_pkg::*;
#(
  parameter int DEB_CYCLES    = 270000,
  parameter int REPEAT_DELAY  = 13500000,
  parameter int REPEAT_PERIOD = 2700000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_mode,
  input  logic                btn_up,
  output logic                run_en,
  output logic [c_mode_w-1:0] mode,
  output logic                inc_sec,
  output logic                inc_min,
  output logic                inc_hour,
  output logic                inc_day
);

  localparam int c_cnt_w = $clog2(max3(DEB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
  localparam logic [c_cnt_w-1:0] c_rpt_delay  = c_cnt_w'(REPEAT_DELAY);
  localparam logic [c_cnt_w-1:0] c_rpt_period = c_cnt_w'(REPEAT_PERIOD);

  logic w_mode_press;
  logic w_mode_level;
  logic w_up_press;
  logic w_up_level;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(c_cnt_w)) u_deb_mode (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_mode),
    .level   (w_mode_level),
    .press   (w_mode_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(c_cnt_w)) u_deb_up (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_up),
    .level   (w_up_level),
    .press   (w_up_press)
  );

  mode_t              r_state;
  mode_t              w_next_state;
  logic               r_run_en;
  logic               r_inc_sec, r_inc_min, r_inc_hour, r_inc_day;
  logic               r_armed;
  logic               r_repeating;
  logic [c_cnt_w-1:0] r_rpt_cnt;

  logic               w_state_chg;
  logic               w_in_set;
  logic               w_first;
  logic               w_rpt_fire;
  logic               w_pulse;
  logic [c_cnt_w-1:0] w_rpt_target;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RUN:      if (w_mode_press) w_next_state = SET_SEC;
      SET_SEC:  if (w_mode_press) w_next_state = SET_MIN;
      SET_MIN:  if (w_mode_press) w_next_state = SET_HOUR;
      SET_HOUR: if (w_mode_press) w_next_state = SET_DAY;
      SET_DAY:  if (w_mode_press) w_next_state = RUN;
      default:  w_next_state = RUN;
    endcase

    w_state_chg  = (w_next_state != r_state);
    w_in_set     = (r_state == SET_SEC) || (r_state == SET_MIN) ||
                   (r_state == SET_HOUR) || (r_state == SET_DAY);
    // a mode press in the same cycle changes state, which swallows the up event
    w_first      = w_up_press && w_in_set && !w_state_chg;
    w_rpt_target = r_repeating ? c_rpt_period : c_rpt_delay;
    w_rpt_fire   = r_armed && w_up_level && !w_state_chg && (r_rpt_cnt == w_rpt_target);
    w_pulse      = w_first || w_rpt_fire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_run_en    <= 1'b1;
      r_inc_sec   <= 1'b0;
      r_inc_min   <= 1'b0;
      r_inc_hour  <= 1'b0;
      r_inc_day   <= 1'b0;
      r_armed     <= 1'b0;
      r_repeating <= 1'b0;
      r_rpt_cnt   <= '0;
    end else begin
      r_state    <= w_next_state;
      r_run_en   <= (w_next_state == RUN);
      r_inc_sec  <= w_pulse && (r_state == SET_SEC);
      r_inc_min  <= w_pulse && (r_state == SET_MIN);
      r_inc_hour <= w_pulse && (r_state == SET_HOUR);
      r_inc_day  <= w_pulse && (r_state == SET_DAY);

      // r_rpt_cnt holds the number of cycles since the last emitted pulse
      if (w_state_chg || !w_up_level) begin
        r_armed     <= 1'b0;
        r_repeating <= 1'b0;
        r_rpt_cnt   <= '0;
      end else if (w_first) begin
        r_armed     <= 1'b1;
        r_repeating <= 1'b0;
        r_rpt_cnt   <= c_cnt_w'(1);
      end else if (r_armed) begin
        if (w_rpt_fire) begin
          r_repeating <= 1'b1;
          r_rpt_cnt   <= c_cnt_w'(1);
        end else begin
          r_rpt_cnt <= r_rpt_cnt + 1'b1;
        end
      end
    end
  end

  assign run_en   = r_run_en;
  assign mode     = r_state;
  assign inc_sec  = r_inc_sec;
  assign inc_min  = r_inc_min;
  assign inc_hour = r_inc_hour;
  assign inc_day  = r_inc_day;

endmodule
`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_time_set_ctrl
//  Description : Directed self-checking bench for time_set_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_time_set_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_mode;
  logic       btn_up;
  logic       run_en;
  logic [2:0] mode;
  logic       inc_sec, inc_min, inc_hour, inc_day;

  int n_assert = 0;
  int n_fail   = 0;

  time_set_ctrl #(
    .DEB_CYCLES    (4),
    .REPEAT_DELAY  (20),
    .REPEAT_PERIOD (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_mode (btn_mode),
    .btn_up   (btn_up),
    .run_en   (run_en),
    .mode     (mode),
    .inc_sec  (inc_sec),
    .inc_min  (inc_min),
    .inc_hour (inc_hour),
    .inc_day  (inc_day)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] incs();
    return {inc_day, inc_hour, inc_min, inc_sec};
  endfunction

  // Clean mode press: mode updates 7 edges after the raw rise (2 sync + 4 debounce + 1 register).
  task automatic press_mode(input logic [2:0] exp_mode);
    btn_mode = 1'b1;
    repeat (6) tick();
    chk("mode_before_update", {29'd0, mode}, {29'd0, (exp_mode == 3'd1) ? 3'd0 : ((exp_mode == 3'd0) ? 3'd4 : exp_mode - 3'd1)});
    tick();
    chk("mode_after_press", {29'd0, mode}, {29'd0, exp_mode});
    chk("run_en_after_press", {31'd0, run_en}, {31'd0, (exp_mode == 3'd0)});
    repeat (3) tick();
    btn_mode = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    rst      = 1'b1;
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    repeat (3) tick();
    chk("reset_mode", {29'd0, mode}, 32'd0);
    chk("reset_run_en", {31'd0, run_en}, 32'd1);
    chk("reset_incs", {28'd0, incs()}, 32'd0);
    rst = 1'b0;
    repeat (3) tick();

    // Bounce: toggle every 2 cycles for 10 cycles, last rise driven at i=8
    for (int i = 0; i < 10; i++) begin
      btn_mode = ((i / 2) % 2) == 0;
      tick();
      chk("bounce_mode_hold", {29'd0, mode}, 32'd0);
    end
    btn_mode = 1'b1;
    for (int i = 3; i <= 6; i++) begin
      tick();
      chk("bounce_mode_wait", {29'd0, mode}, 32'd0);
    end
    tick();
    chk("bounce_mode_step", {29'd0, mode}, 32'd1);
    chk("bounce_run_en", {31'd0, run_en}, 32'd0);
    repeat (10) tick();
    btn_mode = 1'b0;
    repeat (12) tick();
    chk("bounce_single_step", {29'd0, mode}, 32'd1);

    // Mode cycling from a fresh reset
    rst = 1'b1;
    tick();
    chk("reset2_mode", {29'd0, mode}, 32'd0);
    rst = 1'b0;
    repeat (2) tick();
    press_mode(3'd1);
    press_mode(3'd2);
    press_mode(3'd3);
    press_mode(3'd4);
    press_mode(3'd0);

    // Set and repeat in SET_MIN
    press_mode(3'd1);
    press_mode(3'd2);
    btn_up = 1'b1;
    repeat (6) tick();
    chk("min_press_cycle", {28'd0, incs()}, 32'd0);
    for (int k = 1; k <= 45; k++) begin
      tick();
      chk("min_repeat_inc_min", {31'd0, inc_min},
          {31'd0, (k == 1 || k == 21 || k == 26 || k == 31 || k == 36)});
      chk("min_repeat_others", {29'd0, inc_sec, inc_hour, inc_day}, 32'd0);
      if (k == 34) btn_up = 1'b0;
    end
    repeat (10) tick();

    // Conflict in SET_HOUR: simultaneous mode and up presses
    press_mode(3'd3);
    btn_mode = 1'b1;
    btn_up   = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      chk("conflict_no_inc", {28'd0, incs()}, 32'd0);
    end
    chk("conflict_mode", {29'd0, mode}, 32'd4);
    btn_mode = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("conflict_held_no_inc", {28'd0, incs()}, 32'd0);
    end
    btn_up = 1'b0;
    repeat (10) tick();

    // Fresh press in SET_DAY, then reset during repeat
    btn_up = 1'b1;
    repeat (6) tick();
    tick();
    chk("day_first_pulse", {28'd0, incs()}, 32'h8);
    repeat (19) tick();
    chk("day_before_repeat", {28'd0, incs()}, 32'd0);
    tick();
    chk("day_repeat_pulse", {28'd0, incs()}, 32'h8);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_repeat_mode", {29'd0, mode}, 32'd0);
    chk("rst_mid_repeat_run_en", {31'd0, run_en}, 32'd1);
    chk("rst_mid_repeat_incs", {28'd0, incs()}, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      chk("after_rst_no_inc", {28'd0, incs()}, 32'd0);
      chk("after_rst_mode", {29'd0, mode}, 32'd0);
    end
    btn_up = 1'b0;
    repeat (10) tick();

    // Clean up press in RUN is ignored
    btn_up = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      chk("run_ignore_inc", {28'd0, incs()}, 32'd0);
    end
    chk("run_ignore_run_en", {31'd0, run_en}, 32'd1);
    btn_up = 1'b0;
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 270000, consecutive stable cycles needed to accept a button level (10 ms at 27 MHz).
REQ-002 SHALL have parameter REPEAT_DELAY, default 13500000, cycles `btn_up` must be held before auto-repeat starts.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 2700000, cycles between auto-repeat pulses.
REQ-004 SHALL have port `clk`, input, 1 bit: the single system clock.
REQ-005 SHALL have port `rst`, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port `btn_mode`, input, 1 bit: raw mode button, active-high, asynchronous to `clk`.
REQ-007 SHALL have port `btn_up`, input, 1 bit: raw increment button, active-high, asynchronous to `clk`.
REQ-008 SHALL have port `run_en`, output, 1 bit: high means the time counters free-run.
REQ-009 SHALL have port `mode`, output, 3 bits: current state encoding.
REQ-010 SHALL have ports `inc_sec`, `inc_min`, `inc_hour`, `inc_day`, output, 1 bit each: single-cycle increment pulses to the counters.

Function
REQ-011 SHALL pass each raw button through a 2-flop synchronizer.
REQ-012 SHALL update a debounced level only after the synchronized input differs from it for DEB_CYCLES consecutive cycles; any bounce restarts the count.
REQ-013 SHALL form a press event as a one-cycle rising edge of the debounced level; releases generate no event.
REQ-014 SHALL implement states RUN=0, SET_SEC=1, SET_MIN=2, SET_HOUR=3, SET_DAY=4; encodings 5-7 SHALL return to RUN on the next cycle.
REQ-015 SHALL advance on each mode press: RUN->SET_SEC->SET_MIN->SET_HOUR->SET_DAY->RUN.
REQ-016 SHALL drive `run_en` = 1 only in RUN; `mode` SHALL be the registered state.
REQ-017 SHALL, in a SET state, assert the selected `inc_*` for exactly one cycle, on the cycle after the up press event.
REQ-018 SHALL ignore up presses and holds in RUN.
REQ-019 SHALL, while debounced up stays high in a SET state, emit the first repeat pulse REPEAT_DELAY cycles after the press event and further pulses every REPEAT_PERIOD cycles, until release.
REQ-020 SHALL treat mode and up press events in the same cycle as mode only; the up event is dropped.
REQ-021 SHALL, on any state change, clear the repeat counter and suppress pulses until up is released and pressed again.
REQ-022 SHALL never assert more than one `inc_*` output in any cycle.
REQ-023 SHALL register all outputs, with no combinational path from inputs to outputs.

Reset
REQ-024 SHALL, while `rst`=1 at a `clk` edge, set state=RUN, `run_en`=1, `mode`=0, all `inc_*`=0, synchronizers, debounced levels and all counters=0.
REQ-025 SHALL, when reset is asserted mid-press or mid-repeat, emit no pulse on the reset cycle or after it until a fresh debounced press.

Structure
REQ-026 SHALL take the state encoding constants (RUN..SET_DAY) and the `mode` width from the shared package `time_pkg`.
REQ-027 SHALL instantiate sub-module `btn_debounce` (synchronizer, debounce counter, press-event output) twice, once per button.
REQ-028 SHALL size the counters to clog2 of the largest parameter, plus 1.

Verification
REQ-029 Bench SHALL use DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5.
REQ-030 Bounce: `btn_mode` toggles every 2 cycles for 10 cycles, then stays high -> `mode` 0->1 exactly once, 2+4 cycles after the level stabilises, plus the registered output cycle.
REQ-031 Mode cycling: 5 clean mode presses -> `mode` sequence 1,2,3,4,0; `run_en`=0 for states 1-4 and 1 back in RUN.
REQ-032 Set and repeat: in SET_MIN, hold up for 40 cycles after its press event -> `inc_min` pulses at offsets +1, +21, +26, +31, +36 (5 pulses); other `inc_*` stay 0.
REQ-033 Conflict: mode and up press events land in the same cycle in SET_HOUR -> `mode`=4, zero `inc_*` pulses; up still held -> no pulses until re-pressed.
REQ-034 RUN ignore and reset: an up press in RUN -> no pulses; `rst` asserted for 1 cycle during repeat in SET_DAY -> `mode`=0, `run_en`=1, no `inc_day` pulse afterwards.
